// File: rtl/pipe_pkg.sv
// Shared types and default widths for the handshake pipeline stage.
package pipe_pkg;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CNT_W  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Valid/ready pipeline stage with stall counter. Macro PIPE_STAGE_SKID_EN selects a
// 2-entry skid buffer (registered in_ready); otherwise a single entry with combinational in_ready.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_t       state;
    logic [DATA_W-1:0] data_q;
    logic              push;
    logic              pop;

    assign out_valid = (state != EMPTY);
    assign out_data  = data_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] skid;
    logic              ready_q;

    // in_ready is a pure register so out_ready never reaches upstream combinationally.
    assign in_ready = ready_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= EMPTY;
            data_q  <= RESET_VAL;
            skid    <= RESET_VAL;
            ready_q <= 1'b1;
        end else if (flush) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        data_q <= in_data;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        data_q <= in_data;
                    end else if (push) begin
                        skid    <= in_data;
                        state   <= TWO;
                        ready_q <= 1'b0;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // Older entry sits on data_q; the skid entry moves up on pop.
                    if (pop) begin
                        data_q  <= skid;
                        state   <= ONE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= EMPTY;
            data_q <= RESET_VAL;
        end else if (flush) begin
            state <= EMPTY;
        end else if (push) begin
            data_q <= in_data;
            state  <= ONE;
        end else if (pop) begin
            state <= EMPTY;
        end
    end
`endif

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed + scoreboard bench for pipe_stage_hs; expectations follow PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;

    localparam int                DW   = 16;
    localparam logic [DW-1:0]     RVAL = 16'h5A5A;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [31:0]   stall_cnt;

    logic          s_flush;
    logic          s_in_valid;
    logic [7:0]    s_in_data;
    logic          s_in_ready;
    logic          s_out_valid;
    logic [7:0]    s_out_data;
    logic          s_out_ready;
    logic [3:0]    s_stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(DW), .RESET_VAL(RVAL), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_hs #(.DATA_W(8), .RESET_VAL(8'h00), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
        .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
        .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b1; in_data = 16'h0077; out_ready = 1'b0; flush = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        n_checks++; if (out_data !== RVAL) begin n_fail++; $display("FAIL reset_out_data got %h exp %h", out_data, RVAL); end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
        reset = 1'b1; in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tick();
    endtask

    task automatic test_streaming();
        logic [DW-1:0] exp;
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = DW'(i);
            tick();
            exp = DW'(i);
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                n_fail++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0003) begin
            n_fail++; $display("FAIL stream_drain got v=%b d=%h exp v=0 d=0003", out_valid, out_data);
        end
        n_checks++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL stream_stall got %0d exp 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h000A;
        tick();
        in_data = 16'h000B;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        in_valid = 1'b0;
`endif
        #1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h000A) begin
            n_fail++; $display("FAIL bp_hold got v=%b d=%h exp v=1 d=000a", out_valid, out_data);
        end
        tick(); tick();
        n_checks++; if (out_data !== 16'h000A) begin n_fail++; $display("FAIL bp_hold2 got %h exp 000a", out_data); end
        n_checks++; if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL bp_stall got %0d exp 3", stall_cnt); end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 16'h000B) begin
            n_fail++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=000b", out_valid, out_data);
        end
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h000B) begin
            n_fail++; $display("FAIL bp_empty got v=%b d=%h exp v=0 d=000b", out_valid, out_data);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full_in_ready got %b exp 0", in_ready); end
        flush = 1'b1; in_data = 16'h000C;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 16'h0011) begin
            n_fail++; $display("FAIL flush_clear got v=%b d=%h exp v=0 d=0011", out_valid, out_data);
        end
        n_checks++; if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL flush_stall got %0d exp 5", stall_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0 || out_data === 16'h000C) begin
                n_fail++; $display("FAIL flush_no_c got v=%b d=%h exp v=0", out_valid, out_data);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0033;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || out_data !== RVAL || stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rst_stall got v=%b d=%h c=%0d exp v=0 d=%h c=0", out_valid, out_data, stall_cnt, RVAL);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_saturation();
        s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 8'h5C;
        tick();
        s_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (s_stall_cnt !== 4'd5) begin n_fail++; $display("FAIL sat_mid got %0d exp 5", s_stall_cnt); end
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_full got %0d exp 15", s_stall_cnt); end
        for (int i = 0; i < 5; i++) tick();
        n_checks++; if (s_stall_cnt !== 4'd15 || s_out_data !== 8'h5C) begin
            n_fail++; $display("FAIL sat_hold got c=%0d d=%h exp c=15 d=5c", s_stall_cnt, s_out_data);
        end
        s_out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random_stream();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp;
        int            bad = 0;
        logic          do_push, do_pop;
        in_valid = 1'b0; out_ready = 1'b0;
        tick();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!in_valid) in_data = DW'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            do_push = in_valid && in_ready;
            do_pop  = out_valid && out_ready;
            if (do_pop) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_pop_empty cyc=%0d got d=%h exp no valid", cyc, out_data);
                end else begin
                    exp = q.pop_front();
                    if (out_data !== exp) begin
                        n_fail++; bad++;
                        if (bad < 10) $display("FAIL rand_order cyc=%0d got %h exp %h", cyc, out_data, exp);
                    end
                end
            end
            if (do_push) q.push_back(in_data);
            tick();
            if (do_push) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid) begin
                n_checks++;
                exp = (q.size() != 0) ? q.pop_front() : ~out_data;
                if (out_data !== exp) begin n_fail++; $display("FAIL rand_drain got %h exp %h", out_data, exp); end
            end
            tick();
        end
        n_checks++; if (q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rand_leftover got q=%0d v=%b exp q=0 v=0", q.size(), out_valid);
        end
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        test_saturation();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
